// File: rtl/reg_bank_pkg.sv
// Shared constants for the reg_bank register file: FSM state encoding and
// wait-counter width.
package reg_bank_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned CNT_W   = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WAIT = 2'd1;
  localparam state_t S_RESP = 2'd2;

endpackage

// File: rtl/reg_bank_mem.sv
// Register storage for reg_bank: DEPTH x DATA_W flops, synchronous write,
// combinational read, synchronous reset to RESET_VAL.
module reg_bank_mem #(
  parameter int unsigned          ADDR_W    = 4,
  parameter int unsigned          DATA_W    = 4,
  parameter int unsigned          DEPTH     = 12,
  parameter logic [DATA_W-1:0]    RESET_VAL = DATA_W'(4'h5)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!reset_n) begin
        regs[i] <= RESET_VAL;
      end else if (we && (waddr == ADDR_W'(i))) begin
        regs[i] <= wdata;
      end
    end
  end

  // Decoded read mux; unimplemented addresses read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (raddr == ADDR_W'(i)) begin
        rdata = regs[i];
      end
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Single-outstanding register-bank slave: valid/ready request, programmable
// wait, held response until rready. Writes commit when the response retires.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 4,
  parameter int unsigned       DATA_W    = 4,
  parameter int unsigned       DEPTH     = 12,
  parameter int unsigned       WAIT      = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(4'h5)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valid,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT == 0) ? '0 : CNT_W'(WAIT - 1);
  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W+1)'(DEPTH);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;

  logic               req_write;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;

  logic               cur_write;
  logic [ADDR_W-1:0]  cur_addr;
  logic               cur_err;
  logic               req_err;
  logic               enter_resp;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_rdata;

  // With WAIT=0 the response loads on the accept edge, before the request
  // registers hold the new request, so use the live inputs while idle.
  assign cur_write  = (state == S_IDLE) ? write : req_write;
  assign cur_addr   = (state == S_IDLE) ? addr  : req_addr;
  assign cur_err    = ({1'b0, cur_addr} >= DEPTH_L);
  assign req_err    = ({1'b0, req_addr} >= DEPTH_L);
  assign enter_resp = (state_nx == S_RESP) && (state != S_RESP);
  assign mem_we     = (state == S_RESP) && rready && req_write && !req_err;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (valid) begin
          if (WAIT == 0) begin
            state_nx = S_RESP;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nx = S_RESP;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_RESP: begin
        if (rready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request capture and registered response outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      ready     <= 1'b1;
      rvalid    <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      if (valid && ready) begin
        req_write <= write;
        req_addr  <= addr;
        req_wdata <= wdata;
      end
      ready  <= (state_nx == S_IDLE);
      rvalid <= (state_nx == S_RESP);
      if (enter_resp) begin
        err   <= cur_err;
        rdata <= (cur_write || cur_err) ? '0 : mem_rdata;
      end else if (state_nx != S_RESP) begin
        err   <= 1'b0;
        rdata <= '0;
      end
    end
  end

  reg_bank_mem #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL)
  ) u_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (mem_we),
    .waddr   (req_addr),
    .wdata   (req_wdata),
    .raddr   (cur_addr),
    .rdata   (mem_rdata)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: main instance (WAIT=1, DEPTH=12) plus
// WAIT=0 and WAIT=7/DEPTH=16 instances for throughput and latency corners.
module tb_reg_bank;

  localparam int unsigned MAIN_WAIT = 1;

  typedef struct {
    logic [3:0] rdata;
    logic       err;
    int         acc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       valid = 1'b0, write = 1'b0, rready = 1'b1;
  logic [3:0] addr = '0, wdata = '0;
  logic       ready, rvalid, err;
  logic [3:0] rdata;

  logic       v0 = 1'b0, w0 = 1'b0, rr0 = 1'b1;
  logic [3:0] a0 = '0, wd0 = '0;
  logic       ready0, rvalid0, err0;
  logic [3:0] rdata0;

  logic       v7 = 1'b0, w7 = 1'b0, rr7 = 1'b1;
  logic [3:0] a7 = '0, wd7 = '0;
  logic       ready7, rvalid7, err7;
  logic [3:0] rdata7;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   in_resp = 1'b0;
  exp_t sb[$];
  exp_t cur;

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  reg_bank #(.ADDR_W(4), .DATA_W(4), .DEPTH(12), .WAIT(MAIN_WAIT), .RESET_VAL(4'h5)) dut (
    .clock(clock), .reset_n(reset_n), .valid(valid), .write(write), .addr(addr),
    .wdata(wdata), .ready(ready), .rvalid(rvalid), .rready(rready), .rdata(rdata), .err(err)
  );

  reg_bank #(.ADDR_W(4), .DATA_W(4), .DEPTH(12), .WAIT(0), .RESET_VAL(4'h5)) dut0 (
    .clock(clock), .reset_n(reset_n), .valid(v0), .write(w0), .addr(a0),
    .wdata(wd0), .ready(ready0), .rvalid(rvalid0), .rready(rr0), .rdata(rdata0), .err(err0)
  );

  reg_bank #(.ADDR_W(4), .DATA_W(4), .DEPTH(16), .WAIT(7), .RESET_VAL(4'h5)) dut7 (
    .clock(clock), .reset_n(reset_n), .valid(v7), .write(w7), .addr(a7),
    .wdata(wd7), .ready(ready7), .rvalid(rvalid7), .rready(rr7), .rdata(rdata7), .err(err7)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation on each new response and holds it for the
  // whole RESP window, so stability is checked against the bench's value.
  always @(negedge clock) begin
    if (mon_en && reset_n) begin
      if (rvalid) begin
        if (!in_resp) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: got rvalid=1 expected no response (cycle %0d)", cyc);
          end else begin
            cur = sb.pop_front();
            in_resp = 1'b1;
            chk("latency", 32'(cyc - cur.acc + 1), 32'(MAIN_WAIT + 1));
          end
        end
        if (in_resp) begin
          chk("rdata", 32'(rdata), 32'(cur.rdata));
          chk("err", 32'(err), 32'(cur.err));
          chk("ready_in_resp", 32'(ready), 32'd0);
          if (rready) in_resp = 1'b0;
        end
      end else begin
        chk("idle_rdata_zero", 32'(rdata), 32'd0);
        chk("idle_err_zero", 32'(err), 32'd0);
      end
    end else begin
      in_resp = 1'b0;
    end
  end

  task automatic issue(input logic w, input logic [3:0] a, input logic [3:0] d,
                       input logic [3:0] er, input logic ee, input bit expect_resp);
    int n = 0;
    while (!ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (!ready) chk("issue_ready_timeout", 32'(ready), 32'd1);
    valid = 1'b1; write = w; addr = a; wdata = d;
    @(posedge clock); #1;
    valid = 1'b0;
    if (expect_resp) sb.push_back('{rdata: er, err: ee, acc: cyc});
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || in_resp || !ready) && n < 100) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 100) chk("response_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int n;

    // Reset behaviour, during assertion and first cycle after release
    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("in_reset");
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_idle_outputs("post_reset");
    mon_en = 1'b1;

    issue(1'b0, 4'd3, 4'h0, 4'h5, 1'b0, 1'b1);
    wait_done();

    // Write held pending with rready=0; register must not change yet
    rready = 1'b0;
    issue(1'b1, 4'd2, 4'hA, 4'h0, 1'b0, 1'b1);
    n = 0;
    while (!in_resp && n < 20) begin
      @(posedge clock); #1; n++;
    end
    chk("held_reached_resp", 32'(in_resp), 32'd1);
    chk("reg2_while_pending", 32'(dut.u_mem.regs[2]), 32'h5);
    for (int k = 0; k < 5; k++) begin
      valid = (k == 2);
      write = 1'b0;
      addr  = 4'd5;
      chk("held_rvalid", 32'(rvalid), 32'd1);
      chk("held_ready", 32'(ready), 32'd0);
      @(posedge clock); #1;
    end
    valid = 1'b0;
    chk("reg2_after_hold", 32'(dut.u_mem.regs[2]), 32'h5);
    rready = 1'b1;
    wait_done();
    issue(1'b0, 4'd2, 4'h0, 4'hA, 1'b0, 1'b1);
    wait_done();

    // Out-of-range accesses
    issue(1'b0, 4'd13, 4'h0, 4'h0, 1'b1, 1'b1);
    wait_done();
    issue(1'b1, 4'd12, 4'h3, 4'h0, 1'b1, 1'b1);
    wait_done();
    issue(1'b0, 4'd0, 4'h0, 4'h5, 1'b0, 1'b1);
    wait_done();
    issue(1'b0, 4'd11, 4'h0, 4'h5, 1'b0, 1'b1);
    wait_done();

    // Reset during WAIT of a write: no response, write discarded
    issue(1'b1, 4'd1, 4'hF, 4'h0, 1'b0, 1'b0);
    chk("midreset_no_rvalid", 32'(rvalid), 32'd0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_idle_outputs("midreset");
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("reg1_after_reset", 32'(dut.u_mem.regs[1]), 32'h5);
    issue(1'b0, 4'd1, 4'h0, 4'h5, 1'b0, 1'b1);
    wait_done();
    issue(1'b0, 4'd2, 4'h0, 4'h5, 1'b0, 1'b1);
    wait_done();

    // WAIT=0: valid held high accepts every second cycle
    v0 = 1'b1; a0 = 4'd4;
    for (int k = 0; k < 6; k++) begin
      chk("w0_ready", 32'(ready0), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("w0_rvalid", 32'(rvalid0), (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("w0_rdata", 32'(rdata0), (k % 2 == 1) ? 32'h5 : 32'h0);
      @(posedge clock); #1;
    end
    v0 = 1'b0;

    // WAIT=7 with fully populated address space: top address is in range
    v7 = 1'b1; a7 = 4'd15;
    @(posedge clock); #1;
    v7 = 1'b0;
    n = 1;
    while (!rvalid7 && n < 20) begin
      @(posedge clock); #1; n++;
    end
    chk("w7_latency", 32'(n), 32'd8);
    chk("w7_rdata", 32'(rdata7), 32'h5);
    chk("w7_err", 32'(err7), 32'd0);
    @(posedge clock); #1;
    chk("w7_ready_after", 32'(ready7), 32'd1);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning address width in bits.
REQ-002 SHALL have parameter DATA_W, default 4, meaning data width in bits.
REQ-003 SHALL have parameter DEPTH, default 12, meaning number of implemented registers; legal range 1..2^ADDR_W.
REQ-004 SHALL have parameter WAIT, default 1, meaning wait cycles between request acceptance and response; legal range 0..7.
REQ-005 SHALL have parameter RESET_VAL, default 4'h5 zero-extended to DATA_W, meaning reset contents of every register.
REQ-006 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port valid, input, 1, request valid.
REQ-009 SHALL have port write, input, 1, request type: 1 write, 0 read.
REQ-010 SHALL have port addr, input, ADDR_W, request address.
REQ-011 SHALL have port wdata, input, DATA_W, write data.
REQ-012 SHALL have port ready, output, 1, block can accept a request this cycle.
REQ-013 SHALL have port rvalid, output, 1, response valid.
REQ-014 SHALL have port rready, input, 1, requester accepts the response.
REQ-015 SHALL have port rdata, output, DATA_W, read data; 0 for writes and errors.
REQ-016 SHALL have port err, output, 1, the response is for an out-of-range address.

Function
REQ-017 SHALL accept a request on a rising edge where valid and ready are both 1, capturing write, addr and wdata.
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP; ready=1 only in IDLE, rvalid=1 only in RESP.
REQ-019 SHALL transition IDLE->WAIT on acceptance when WAIT>0, and IDLE->RESP when WAIT=0.
REQ-020 SHALL load a 3-bit wait counter with WAIT-1 on acceptance, decrement it each WAIT cycle, and go WAIT->RESP in the cycle after it reads 0.
REQ-021 SHALL give a response latency from accept edge to first rvalid=1 cycle of WAIT+1 cycles.
REQ-022 SHALL hold rvalid, rdata and err stable in RESP until rready=1, then go RESP->IDLE on that edge.
REQ-023 SHALL allow at most one outstanding request; valid while ready=0 is ignored and does not need to be held by the requester.
REQ-024 SHALL perform an in-range write (addr<DEPTH) on the RESP->IDLE edge, so the register keeps its old value while the response is pending.
REQ-025 SHALL return the register value sampled on the WAIT->RESP or IDLE->RESP edge for an in-range read.
REQ-026 SHALL treat addr>=DEPTH as an error: err=1, rdata=0, no register modified; when DEPTH=2^ADDR_W, err is never asserted.
REQ-027 SHALL drive rdata=0 and err=0 whenever rvalid=0.
REQ-028 SHALL make a read issued after a completed write to the same address return the written value.

Reset
REQ-029 SHALL, on reset_n=0 at a rising edge, force the FSM to IDLE, the wait counter to 0, every register to RESET_VAL and the captured request to 0.
REQ-030 SHALL, while reset is asserted and in the first cycle after release, present ready=1, rvalid=0, rdata=0, err=0.
REQ-031 SHALL, when reset is asserted mid-transaction (WAIT or RESP), discard the transaction, emit no response and perform no pending write.

Structure
REQ-032 SHALL take the FSM state enumeration (2-bit, IDLE=0, WAIT=1, RESP=2) from a shared package reg_bank_pkg, together with the wait-counter width constant (3).
REQ-033 SHALL be split into a storage sub-module reg_bank_mem (DEPTH x DATA_W registers, synchronous write, combinational read, reset to RESET_VAL), with the FSM and handshake logic in reg_bank.

Verification
REQ-034 SHALL cover: reset, then read addr 3 with rready=1 and WAIT=1 -> rvalid on cycle 2 after accept, rdata=4'h5, err=0.
REQ-035 SHALL cover: write addr 2 with wdata 4'hA, then read addr 2 -> rdata=4'hA; addr 2 still reads 4'h5 while the write response is held with rready=0.
REQ-036 SHALL cover: read addr 13 with DEPTH=12 -> err=1, rdata=0; a following read of addr 0 returns 4'h5, confirming no side effect.
REQ-037 SHALL cover: rready held 0 for 5 cycles in RESP -> rvalid, rdata and err stable throughout, ready=0, and a second valid pulse during that window is ignored.
REQ-038 SHALL cover: WAIT=0 -> back-to-back accepts every 2 cycles with rready=1; WAIT=7 -> latency of 8 cycles.
REQ-039 SHALL cover: reset_n=0 asserted in WAIT during a write of 4'hF to addr 1 -> no rvalid, addr 1 reads 4'h5 after reset.
